stopwatch_display: RTL and testbench

Downstream consumer of the stopwatch counter block. Periodically snapshots its binary ms/sec/min/hs outputs and converts them to BCD with a sequential shift-add-3 converter. Drives a 10-digit multiplexed 7-segment display in the format hh.mm.ss.ffff. Sits between the counter and the board's display pins.

---
 rtl/stopwatch_pkg.sv | 103 ++++++++++
 rtl/stopwatch_display_bin2bcd_seq.sv | 53 +++++
 rtl/stopwatch_display.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_stopwatch_display.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch display path: field widths, clamp
// limits, seven-segment patterns, conversion FSM states and BCD helpers.
package stopwatch_pkg;

    localparam int MS_W         = 15;
    localparam int HMS_W        = 7;
    localparam int BCD_W        = 16;
    localparam int NUM_DIGITS   = 10;
    localparam int DIGITS_W     = 40;

    localparam logic [MS_W-1:0]  MS_MAX  = 15'd9999;
    localparam logic [HMS_W-1:0] HMS_MAX = 7'd99;

    // Index of the shift cycle that completes a conversion (15 shifts: 0..14)
    localparam logic [3:0] SHIFT_LAST = 4'd14;

    // Segment patterns, gfedcba, active-low
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Scan indices that carry a decimal point (units digit of sec, min, hs)
    localparam logic [3:0] DP_IDX_SEC  = 4'd4;
    localparam logic [3:0] DP_IDX_MIN  = 4'd6;
    localparam logic [3:0] DP_IDX_HS   = 4'd8;
    localparam logic [3:0] SCAN_IDX_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD_F = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_COMMIT = 2'd3
    } conv_state_t;

    typedef enum logic [1:0] {
        FLD_MS  = 2'd0,
        FLD_SEC = 2'd1,
        FLD_MIN = 2'd2,
        FLD_HS  = 2'd3
    } field_t;

    // Conversion order is ms, sec, min, hs
    function automatic field_t next_field(input field_t f);
        field_t r;
        case (f)
            FLD_MS:  r = FLD_SEC;
            FLD_SEC: r = FLD_MIN;
            FLD_MIN: r = FLD_HS;
            FLD_HS:  r = FLD_MS;
            default: r = FLD_MS;
        endcase
        return r;
    endfunction

    function automatic logic [MS_W-1:0] clamp_ms(input logic [MS_W-1:0] v);
        return (v > MS_MAX) ? MS_MAX : v;
    endfunction

    function automatic logic [HMS_W-1:0] clamp_hms(input logic [HMS_W-1:0] v);
        return (v > HMS_MAX) ? HMS_MAX : v;
    endfunction

    // Double-dabble correction: any nibble >= 5 would exceed 9 after doubling
    function automatic logic [BCD_W-1:0] add3_nibbles(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (b[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
            end else begin
                r[i*4 +: 4] = b[i*4 +: 4];
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/stopwatch_display_bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter: one load cycle followed by
// fifteen shift cycles. Shared by all four time fields.
module bin2bcd_seq
    import stopwatch_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [MS_W-1:0]  bin,
    output logic [BCD_W-1:0] bcd,
    output logic             done
);

    logic [MS_W-1:0]  bin_r;
    logic [BCD_W-1:0] bcd_r;
    logic [3:0]       shift_cnt_r;
    logic             running_r;
    logic [BCD_W-1:0] adj_s;

    // Nibble correction applied before each shift
    always_comb begin
        adj_s = add3_nibbles(bcd_r);
    end

    // Load on start, then shift one binary bit into the BCD register per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_r       <= 15'd0;
            bcd_r       <= 16'd0;
            shift_cnt_r <= 4'd0;
            running_r   <= 1'b0;
        end else if (start) begin
            bin_r       <= bin;
            bcd_r       <= 16'd0;
            shift_cnt_r <= 4'd0;
            running_r   <= 1'b1;
        end else if (running_r) begin
            bcd_r <= {adj_s[BCD_W-2:0], bin_r[MS_W-1]};
            bin_r <= {bin_r[MS_W-2:0], 1'b0};
            if (shift_cnt_r == SHIFT_LAST) begin
                shift_cnt_r <= 4'd0;
                running_r   <= 1'b0;
            end else begin
                shift_cnt_r <= shift_cnt_r + 4'd1;
            end
        end
    end

    assign bcd = bcd_r;
    // High during the cycle whose closing edge performs the final shift
    assign done = running_r && (shift_cnt_r == SHIFT_LAST);

endmodule

// File: rtl/stopwatch_display.sv
// Snapshots the stopwatch counter, converts each field to BCD with a shared
// sequential converter and drives a 10-digit multiplexed 7-segment display.
module stopwatch_display
    import stopwatch_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int SCAN_DIV    = 1000
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic [MS_W-1:0]     ms,
    input  logic [HMS_W-1:0]    sec,
    input  logic [HMS_W-1:0]    min,
    input  logic [HMS_W-1:0]    hs,
    output logic [6:0]          seg_n,
    output logic                dp_n,
    output logic [NUM_DIGITS-1:0] an_n,
    output logic [DIGITS_W-1:0] digits_bcd,
    output logic                busy
);

    localparam int REF_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_DIV - 1);
    localparam logic [REF_W-1:0]  REF_ONE   = REF_W'(1);
    localparam logic [REF_W-1:0]  REF_ZERO  = REF_W'(0);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_ONE  = SCAN_W'(1);
    localparam logic [SCAN_W-1:0] SCAN_ZERO = SCAN_W'(0);

    generate
        if (REFRESH_DIV < 80) begin : g_bad_refresh_div
            $error("stopwatch_display: REFRESH_DIV must be at least 80");
        end
        if (SCAN_DIV < 1) begin : g_bad_scan_div
            $error("stopwatch_display: SCAN_DIV must be at least 1");
        end
    endgenerate

    // Refresh timing and snapshot
    logic [REF_W-1:0]  refresh_cnt_r;
    logic              tick_s;
    logic              capture_s;
    logic [MS_W-1:0]   snap_ms_r;
    logic [HMS_W-1:0]  snap_sec_r;
    logic [HMS_W-1:0]  snap_min_r;
    logic [HMS_W-1:0]  snap_hs_r;
    logic              busy_r;

    // Conversion FSM
    conv_state_t       state_r;
    conv_state_t       state_nxt_s;
    field_t            field_r;
    field_t            field_nxt_s;
    logic              conv_start_s;
    logic              store_ms_s;
    logic              store_sec_s;
    logic              store_min_s;
    logic              commit_s;

    // Converter interface
    logic [MS_W-1:0]   conv_bin_s;
    logic [BCD_W-1:0]  conv_bcd_s;
    logic              conv_done_s;

    // Partial results and committed value
    logic [BCD_W-1:0]  ms_bcd_r;
    logic [7:0]        sec_bcd_r;
    logic [7:0]        min_bcd_r;
    logic [DIGITS_W-1:0] digits_r;
    logic              shown_r;

    // Scan and display
    logic [SCAN_W-1:0] scan_cnt_r;
    logic [3:0]        scan_idx_r;
    logic [3:0]        scan_digit_s;
    logic [NUM_DIGITS-1:0] an_nxt_s;
    logic [6:0]        seg_nxt_s;
    logic              dp_nxt_s;
    logic [NUM_DIGITS-1:0] an_n_r;
    logic [6:0]        seg_n_r;
    logic              dp_n_r;

    assign tick_s    = (refresh_cnt_r == REF_LAST);
    assign capture_s = tick_s && !busy_r;

    // Free-running refresh divider; starts at its last value so the first
    // edge after reset produces a tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt_r <= REF_LAST;
        end else if (tick_s) begin
            refresh_cnt_r <= REF_ZERO;
        end else begin
            refresh_cnt_r <= refresh_cnt_r + REF_ONE;
        end
    end

    // Clamped snapshot of the counter fields, and the busy flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_ms_r  <= 15'd0;
            snap_sec_r <= 7'd0;
            snap_min_r <= 7'd0;
            snap_hs_r  <= 7'd0;
            busy_r     <= 1'b0;
        end else if (capture_s) begin
            snap_ms_r  <= clamp_ms(ms);
            snap_sec_r <= clamp_hms(sec);
            snap_min_r <= clamp_hms(min);
            snap_hs_r  <= clamp_hms(hs);
            busy_r     <= 1'b1;
        end else if (commit_s) begin
            busy_r     <= 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            field_r <= FLD_MS;
        end else begin
            state_r <= state_nxt_s;
            field_r <= field_nxt_s;
        end
    end

    // FSM next-state: load and shift each field in turn, then commit
    always_comb begin
        state_nxt_s = state_r;
        field_nxt_s = field_r;
        case (state_r)
            ST_IDLE: begin
                if (capture_s) begin
                    state_nxt_s = ST_LOAD_F;
                    field_nxt_s = FLD_MS;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD_F: begin
                state_nxt_s = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (conv_done_s) begin
                    if (field_r == FLD_HS) begin
                        state_nxt_s = ST_COMMIT;
                    end else begin
                        state_nxt_s = ST_LOAD_F;
                        field_nxt_s = next_field(field_r);
                    end
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_COMMIT: begin
                state_nxt_s = ST_IDLE;
                field_nxt_s = FLD_MS;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                field_nxt_s = FLD_MS;
            end
        endcase
    end

    // FSM outputs: a LOAD_F for field N also banks the finished result of N-1
    always_comb begin
        conv_start_s = 1'b0;
        store_ms_s   = 1'b0;
        store_sec_s  = 1'b0;
        store_min_s  = 1'b0;
        commit_s     = 1'b0;
        case (state_r)
            ST_LOAD_F: begin
                conv_start_s = 1'b1;
                store_ms_s   = (field_r == FLD_SEC);
                store_sec_s  = (field_r == FLD_MIN);
                store_min_s  = (field_r == FLD_HS);
            end
            ST_COMMIT: begin
                commit_s = 1'b1;
            end
            default: begin
                conv_start_s = 1'b0;
            end
        endcase
    end

    // Select the snapshot field being converted, zero-extended to 15 bits
    always_comb begin
        case (field_r)
            FLD_MS:  conv_bin_s = snap_ms_r;
            FLD_SEC: conv_bin_s = {8'd0, snap_sec_r};
            FLD_MIN: conv_bin_s = {8'd0, snap_min_r};
            FLD_HS:  conv_bin_s = {8'd0, snap_hs_r};
            default: conv_bin_s = 15'd0;
        endcase
    end

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start_s),
        .bin   (conv_bin_s),
        .bcd   (conv_bcd_s),
        .done  (conv_done_s)
    );

    // Bank per-field results; publish all four fields in one edge on commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ms_bcd_r  <= 16'd0;
            sec_bcd_r <= 8'd0;
            min_bcd_r <= 8'd0;
            digits_r  <= 40'd0;
            shown_r   <= 1'b0;
        end else begin
            if (store_ms_s) begin
                ms_bcd_r <= conv_bcd_s;
            end
            if (store_sec_s) begin
                sec_bcd_r <= conv_bcd_s[7:0];
            end
            if (store_min_s) begin
                min_bcd_r <= conv_bcd_s[7:0];
            end
            if (commit_s) begin
                digits_r <= {conv_bcd_s[7:0], min_bcd_r, sec_bcd_r, ms_bcd_r};
                shown_r  <= 1'b1;
            end
        end
    end

    // Digit scan: idle until something has been committed, then free-running
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt_r <= SCAN_ZERO;
            scan_idx_r <= 4'd0;
        end else if (shown_r) begin
            if (scan_cnt_r == SCAN_LAST) begin
                scan_cnt_r <= SCAN_ZERO;
                scan_idx_r <= (scan_idx_r == SCAN_IDX_MAX) ? 4'd0 : scan_idx_r + 4'd1;
            end else begin
                scan_cnt_r <= scan_cnt_r + SCAN_ONE;
            end
        end
    end

    // Pick the BCD digit belonging to the current scan position
    always_comb begin
        case (scan_idx_r)
            4'd0:    scan_digit_s = digits_r[3:0];
            4'd1:    scan_digit_s = digits_r[7:4];
            4'd2:    scan_digit_s = digits_r[11:8];
            4'd3:    scan_digit_s = digits_r[15:12];
            4'd4:    scan_digit_s = digits_r[19:16];
            4'd5:    scan_digit_s = digits_r[23:20];
            4'd6:    scan_digit_s = digits_r[27:24];
            4'd7:    scan_digit_s = digits_r[31:28];
            4'd8:    scan_digit_s = digits_r[35:32];
            4'd9:    scan_digit_s = digits_r[39:36];
            default: scan_digit_s = 4'hF;
        endcase
    end

    // Next anode/segment/dp pattern; everything dark before the first commit
    always_comb begin
        if (shown_r) begin
            an_nxt_s  = ~(10'd1 << scan_idx_r);
            seg_nxt_s = seg_decode(scan_digit_s);
            dp_nxt_s  = !((scan_idx_r == DP_IDX_SEC) ||
                          (scan_idx_r == DP_IDX_MIN) ||
                          (scan_idx_r == DP_IDX_HS));
        end else begin
            an_nxt_s  = 10'h3FF;
            seg_nxt_s = SEG_BLANK;
            dp_nxt_s  = 1'b1;
        end
    end

    // Display pins registered together so anodes and segments never skew
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_n_r  <= 10'h3FF;
            seg_n_r <= SEG_BLANK;
            dp_n_r  <= 1'b1;
        end else begin
            an_n_r  <= an_nxt_s;
            seg_n_r <= seg_nxt_s;
            dp_n_r  <= dp_nxt_s;
        end
    end

    assign an_n       = an_n_r;
    assign seg_n      = seg_n_r;
    assign dp_n       = dp_n_r;
    assign digits_bcd = digits_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_stopwatch_display.sv
// Self-checking bench for stopwatch_display: a cycle-level behavioural model
// of snapshot/commit/scan timing compared every cycle, plus directed checks.
module tb_stopwatch_display;

    localparam int RD = 100;
    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [14:0] ms  = 15'd0;
    logic [6:0]  sec = 7'd0;
    logic [6:0]  min = 7'd0;
    logic [6:0]  hs  = 7'd0;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [9:0]  an_n;
    logic [39:0] digits_bcd;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;

    stopwatch_display #(.REFRESH_DIV(RD), .SCAN_DIV(SD)) dut (
        .clk        (clk),
        .rst        (rst),
        .ms         (ms),
        .sec        (sec),
        .min        (min),
        .hs         (hs),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .an_n       (an_n),
        .digits_bcd (digits_bcd),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [7:0] dec2(input int v);
        int c;
        c = (v > 99) ? 99 : v;
        return {4'(c / 10), 4'(c % 10)};
    endfunction

    function automatic logic [15:0] dec4(input int v);
        int c;
        c = (v > 9999) ? 9999 : v;
        return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
    endfunction

    function automatic logic [6:0] seg_for(input logic [39:0] dg, input int idx);
        logic [39:0] t;
        t = dg >> (4 * idx);
        return seg_tab[t[3:0]];
    endfunction

    // Model: edges counted from reset release; snapshot on every RD-th edge
    // when idle, result visible 65 edges later; display shows the value
    // committed before each edge at index ((n-first-1)/SD)%10.
    int          m_n;
    int          m_first;
    int          m_cap;
    logic        m_busy;
    logic [39:0] m_digits;
    logic [39:0] m_pend;
    logic [9:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_n      <= 0;
            m_first  <= -1;
            m_cap    <= 0;
            m_busy   <= 1'b0;
            m_digits <= 40'd0;
            m_pend   <= 40'd0;
            e_an     <= 10'h3FF;
            e_seg    <= 7'h7F;
            e_dp     <= 1'b1;
        end else begin
            if (m_first >= 0 && m_n > m_first) begin
                e_an  <= ~(10'd1 << (((m_n - m_first - 1) / SD) % 10));
                e_seg <= seg_for(m_digits, ((m_n - m_first - 1) / SD) % 10);
                e_dp  <= !((((m_n - m_first - 1) / SD) % 10) inside {4, 6, 8});
            end else begin
                e_an  <= 10'h3FF;
                e_seg <= 7'h7F;
                e_dp  <= 1'b1;
            end
            if ((m_n % RD) == 0 && !m_busy) begin
                m_pend <= {dec2(int'(hs)), dec2(int'(min)), dec2(int'(sec)), dec4(int'(ms))};
                m_busy <= 1'b1;
                m_cap  <= m_n;
            end else if (m_busy && m_n == m_cap + 65) begin
                m_digits <= m_pend;
                m_busy   <= 1'b0;
                if (m_first < 0) begin
                    m_first <= m_n;
                end
            end
            m_n <= m_n + 1;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        chk("busy", 64'(busy), 64'(m_busy));
        chk("digits_bcd", 64'(digits_bcd), 64'(m_digits));
        chk("an_n", 64'(an_n), 64'(e_an));
        chk("seg_n", 64'(seg_n), 64'(e_seg));
        chk("dp_n", 64'(dp_n), 64'(e_dp));
    end

    // Advance until edge e (counted from reset release) has happened
    task automatic goto_edge(input int e);
        int guard;
        guard = 0;
        while (m_n != e + 1 && guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (m_n != e + 1) begin
            n_total++;
            $display("FAIL goto_edge: reached edge count %0d, wanted %0d", m_n, e + 1);
        end
        #1;
    endtask

    initial begin
        ms = 15'd7890; sec = 7'd56; min = 7'd34; hs = 7'd12;
        #1 rst = 1'b1;
        #2;
        chk("rst_digits", 64'(digits_bcd), 64'h0);
        chk("rst_an", 64'(an_n), 64'h3FF);
        chk("rst_seg", 64'(seg_n), 64'h7F);
        chk("rst_dp", 64'(dp_n), 64'h1);
        chk("rst_busy", 64'(busy), 64'h0);
        @(posedge clk); @(posedge clk); #2 rst = 1'b0;

        // Test 1: capture on first edge, commit 65 edges later
        goto_edge(0);
        chk("t1_busy_rise", 64'(busy), 64'h1);
        goto_edge(64);
        chk("t1_busy_64", 64'(busy), 64'h1);
        chk("t1_digits_64", 64'(digits_bcd), 64'h0);
        goto_edge(65);
        chk("t1_digits", 64'(digits_bcd), 64'h12_34_56_7890);
        chk("t1_busy_fall", 64'(busy), 64'h0);
        chk("t1_an_pre", 64'(an_n), 64'h3FF);

        // Test 3: scan walk after the first commit
        goto_edge(66);
        chk("t3_an_idx0", 64'(an_n), 64'h3FE);
        chk("t3_seg_idx0", 64'(seg_n), 64'h40);
        chk("t3_dp_idx0", 64'(dp_n), 64'h1);
        goto_edge(70);
        chk("t3_an_idx1", 64'(an_n), 64'h3FD);
        goto_edge(82);
        chk("t3_an_idx4", 64'(an_n), 64'h3EF);
        chk("t3_seg_idx4", 64'(seg_n), 64'h02);
        chk("t3_dp_idx4", 64'(dp_n), 64'h0);

        // Test 2: clamping
        ms = 15'd15000; sec = 7'd120; min = 7'd0; hs = 7'd0;
        goto_edge(102);
        chk("t3_an_idx9", 64'(an_n), 64'h1FF);
        chk("t3_seg_idx9", 64'(seg_n), 64'h79);
        goto_edge(106);
        chk("t3_an_wrap", 64'(an_n), 64'h3FE);
        goto_edge(165);
        chk("t2_digits", 64'(digits_bcd), 64'h00_00_99_9999);

        // Test 4: input change after capture does not leak into result
        ms = 15'd1; sec = 7'd0;
        goto_edge(202);
        ms = 15'd2222;
        goto_edge(265);
        chk("t4_digits_first", 64'(digits_bcd), 64'h00_00_00_0001);
        goto_edge(365);
        chk("t4_digits_next", 64'(digits_bcd), 64'h00_00_00_2222);

        // Test 5: reset in the middle of a conversion
        ms = 15'd4321; sec = 7'd9; min = 7'd59; hs = 7'd23;
        goto_edge(420);
        rst = 1'b1;
        #1;
        chk("t5_seg", 64'(seg_n), 64'h7F);
        chk("t5_an", 64'(an_n), 64'h3FF);
        chk("t5_digits", 64'(digits_bcd), 64'h0);
        chk("t5_busy", 64'(busy), 64'h0);
        @(posedge clk); @(posedge clk); #2 rst = 1'b0;
        goto_edge(64);
        chk("t5_busy_64", 64'(busy), 64'h1);
        chk("t5_digits_64", 64'(digits_bcd), 64'h0);
        goto_edge(65);
        chk("t5_digits", 64'(digits_bcd), 64'h23_59_09_4321);
        chk("t5_busy_fall", 64'(busy), 64'h0);

        // Test 6: all zeros, scan position carried over from earlier commit
        ms = 15'd0; sec = 7'd0; min = 7'd0; hs = 7'd0;
        goto_edge(165);
        chk("t6_digits", 64'(digits_bcd), 64'h0);
        goto_edge(166);
        chk("t6_an_idx5", 64'(an_n), 64'h3DF);
        chk("t6_seg_idx5", 64'(seg_n), 64'h40);
        chk("t6_dp_idx5", 64'(dp_n), 64'h1);
        goto_edge(170);
        chk("t6_dp_idx6", 64'(dp_n), 64'h0);
        chk("t6_seg_idx6", 64'(seg_n), 64'h40);
        goto_edge(178);
        chk("t6_an_idx8", 64'(an_n), 64'h2FF);
        chk("t6_dp_idx8", 64'(dp_n), 64'h0);
        goto_edge(220);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
